display_mux: RTL
================

DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: enabled clk cycles per digit slot, legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 8: dead-time cycles at the start of each slot, legal range 1..SCAN_DIV-1.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 res  in  1  asynchronous, active-high reset.
REQ-005 ena  in  1  scan enable; low freezes all state and holds all outputs.
REQ-006 sec_lo in 4, sec_hi in 3, min_lo in 4, min_hi in 3, hr_lo in 4, hr_hi in 2  BCD time digits from the counter chain.
REQ-007 lz_blank  in  1  high blanks hr_hi when it is 0.
REQ-008 colon  in  1  high lights dp on digits 2 and 4.
REQ-009 seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
REQ-010 dp  out  1  decimal point, active-high, registered.
REQ-011 dig_n  out  6  digit select, one-hot active-low, registered; bit i selects slot i.
REQ-012 frame  out  1  single-cycle pulse when a new snapshot is taken.

Function
REQ-013 Prescaler pcnt SHALL count 0..SCAN_DIV-1 on each clk with ena high, then wrap to 0.
REQ-014 Slot index idx SHALL advance 0..5 and then wrap to 0 on each pcnt wrap; idx 0 = sec_lo, 1 = sec_hi, 2 = min_lo, 3 = min_hi, 4 = hr_lo, 5 = hr_hi.
REQ-015 On the pcnt wrap with idx==5, all six digit inputs SHALL be latched into snapshot registers (zero-extended to 4 bits) in the same edge; frame SHALL pulse high the following cycle.
REQ-016 Displayed data SHALL come only from the snapshot, never from live inputs, so no frame shows a torn time.
REQ-017 Each cycle with ena high, outputs SHALL register from current state: dig_n = all ones while pcnt < BLANK_CYC, else bit idx low; seg = decode(snapshot[idx]); dp = colon AND (idx==2 OR idx==4) AND pcnt >= BLANK_CYC.
REQ-018 Outputs SHALL therefore lag the pcnt/idx state by exactly one cycle.
REQ-019 Decode SHALL use the standard 0-9 patterns (0 = 0111111, 1 = 0000110, 8 = 1111111); values 10-15 SHALL show a dash (1000000).
REQ-020 If lz_blank is high, idx==5 and snapshot[5]==0, then seg SHALL be 0000000 and dig_n bit 5 SHALL stay high.
REQ-021 With ena low, pcnt, idx, snapshot and all outputs SHALL hold; frame SHALL be 0.
REQ-022 At most one dig_n bit SHALL be low in any cycle.

Reset
REQ-023 res high SHALL immediately force pcnt=0, idx=0, snapshot=0, seg=0, dp=0, dig_n=111111 and frame=0.
REQ-024 res asserted mid-slot SHALL abort the scan; after release, the first snapshot SHALL occur after 6*SCAN_DIV enabled cycles.

Structure
REQ-025 The seven-segment patterns, the dash pattern, the slot count (6) and the slot-index width SHALL reside in shared package clock_pkg.
REQ-026 BCD-to-segment decode SHALL be a separate combinational sub-module, seg7_decode, reusable by other display blocks.

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-027 Reset release, ena=1 -> dig_n=111111 for 1 cycle, then 111110 for 3, then 111101; frame first pulses 24 enabled cycles after release.
REQ-028 Inputs 12:34:56, lz_blank=0, after the first frame -> slot 0 seg=1111101 (6), slot 5 seg=0000110 (1).
REQ-029 Inputs change 12:34:56 -> 12:34:57 mid-frame -> slot 0 keeps showing 6 until the next frame pulse, then shows 7.
REQ-030 hr_hi=0, lz_blank=1 -> during slot 5 seg=0000000 and dig_n=111111; with lz_blank=0 -> seg=0111111 and dig_n=011111.
REQ-031 colon=1 -> dp=1 only in the active part of slots 2 and 4; force sec_lo=4'hC -> slot 0 seg=1000000.
REQ-032 ena low for 10 cycles mid-slot -> all outputs constant, and slot length extends by exactly 10 cycles; res pulse mid-slot -> dig_n=111111 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared display constants: slot geometry and seven-segment patterns {g,f,e,d,c,b,a}.
package clock_pkg;

   localparam int unsigned SLOTS = 6;
   localparam int unsigned IDX_W = $clog2(SLOTS);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [3:0]       bcd_t;
   typedef logic [6:0]       seg_t;

   localparam idx_t IDX_LAST = idx_t'(SLOTS - 1);

   localparam seg_t SEG_DASH  = 7'b1000000;
   localparam seg_t SEG_BLANK = 7'b0000000;

   // Element n is the pattern for digit n.
   localparam logic [9:0][6:0] SEG_DIGITS = {
      7'b1101111,  // 9
      7'b1111111,  // 8
      7'b0000111,  // 7
      7'b1111101,  // 6
      7'b1101101,  // 5
      7'b1100110,  // 4
      7'b1001111,  // 3
      7'b1011011,  // 2
      7'b0000110,  // 1
      7'b0111111   // 0
   };

endpackage

// File: rtl/display_mux_if.sv
// Time digits in, multiplexed segment drive out.
interface display_mux_if;
   import clock_pkg::*;

   logic       ena;
   logic [3:0] sec_lo;
   logic [2:0] sec_hi;
   logic [3:0] min_lo;
   logic [2:0] min_hi;
   logic [3:0] hr_lo;
   logic [1:0] hr_hi;
   logic       lz_blank;
   logic       colon;
   seg_t       seg;
   logic       dp;
   logic [5:0] dig_n;
   logic       frame;

   modport master (
      output ena, sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, lz_blank, colon,
      input  seg, dp, dig_n, frame
   );

   modport slave (
      input  ena, sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, lz_blank, colon,
      output seg, dp, dig_n, frame
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decode; non-decimal codes show a dash.
module seg7_decode
   import clock_pkg::*;
(
   input  bcd_t i_bcd,
   input  logic i_blank,
   output seg_t o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      if (i_blank) begin
         o_seg = SEG_BLANK;
      end else if (i_bcd <= 4'd9) begin
         o_seg = SEG_DIGITS[i_bcd];
      end
   end

endmodule

// File: rtl/display_mux.sv
// Six-digit time display scanner: prescaled slot rotation with per-slot dead time,
// fed from a snapshot taken once per frame so a frame never shows a torn time.
module display_mux
   import clock_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 1000,
   parameter int unsigned BLANK_CYC = 8
) (
   input logic         clk,
   input logic         res,
   display_mux_if.slave io_bus
);

   localparam int unsigned PCNT_W = $clog2(SCAN_DIV);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
   localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYC);

   logic [PCNT_W-1:0] r_pcnt;
   idx_t              r_idx;
   bcd_t              r_snap [SLOTS];
   seg_t              r_seg;
   logic              r_dp;
   logic [SLOTS-1:0]  r_dig_n;
   logic              r_frame;

   logic             w_wrap;
   logic             w_last_slot;
   logic             w_active;
   logic             w_lz;
   bcd_t             w_bcd;
   seg_t             w_seg;
   logic [SLOTS-1:0] w_sel_n;

   assign w_wrap      = (r_pcnt == PCNT_LAST);
   assign w_last_slot = (r_idx == IDX_LAST);
   assign w_active    = (r_pcnt >= BLANK_END);
   assign w_bcd       = r_snap[r_idx];
   assign w_lz        = io_bus.lz_blank && w_last_slot && (w_bcd == 4'd0);
   assign w_sel_n     = ~({{(SLOTS-1){1'b0}}, 1'b1} << r_idx);

   seg7_decode u_decode (
      .i_bcd   (w_bcd),
      .i_blank (w_lz),
      .o_seg   (w_seg)
   );

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_pcnt  <= '0;
         r_idx   <= '0;
         r_seg   <= SEG_BLANK;
         r_dp    <= 1'b0;
         r_dig_n <= '1;
         r_frame <= 1'b0;
         for (int i = 0; i < SLOTS; i++) begin
            r_snap[i] <= '0;
         end
      end else begin
         r_frame <= io_bus.ena && w_wrap && w_last_slot;
         if (io_bus.ena) begin
            r_pcnt <= w_wrap ? '0 : r_pcnt + PCNT_W'(1);
            if (w_wrap) begin
               r_idx <= w_last_slot ? '0 : r_idx + idx_t'(1);
            end
            if (w_wrap && w_last_slot) begin
               r_snap[0] <= io_bus.sec_lo;
               r_snap[1] <= {1'b0, io_bus.sec_hi};
               r_snap[2] <= io_bus.min_lo;
               r_snap[3] <= {1'b0, io_bus.min_hi};
               r_snap[4] <= io_bus.hr_lo;
               r_snap[5] <= {2'b00, io_bus.hr_hi};
            end
            // Outputs reflect the pre-edge slot state, hence one cycle behind it.
            r_seg   <= w_seg;
            r_dig_n <= (w_active && !w_lz) ? w_sel_n : '1;
            r_dp    <= io_bus.colon && (r_idx == idx_t'(2) || r_idx == idx_t'(4)) && w_active;
         end
      end
   end

   assign io_bus.seg   = r_seg;
   assign io_bus.dp    = r_dp;
   assign io_bus.dig_n = r_dig_n;
   assign io_bus.frame = r_frame;

endmodule
